// File: rtl/multi_tick_timer.sv
// Multi-channel base-tick timer: shared prescaler plus periodic/one-shot down-counters.
// Optional sticky interrupt pending flags when TIMER_IRQ_EN is defined.
module multi_tick_timer #(
  parameter int CLK_FREQ_MHZ = 36,
  parameter int BASE_US      = 1,
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 16,
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_wr_en,
  input  logic [CHW-1:0]      i_wr_ch,
  input  logic [CNT_W-1:0]    i_wr_period,
  input  logic                i_wr_mode,
  input  logic [CHANNELS-1:0] i_start,
  input  logic [CHANNELS-1:0] i_stop,
  input  logic [CHANNELS-1:0] i_irq_clr,
  output logic                o_base_tick,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_busy,
  output logic                o_irq
);

  localparam int PRESCALE = CLK_FREQ_MHZ * BASE_US;
  localparam int PW       = $clog2(PRESCALE);

  logic [PW-1:0] pre_q, pre_d;
  logic          s;
  logic          bt_q;

  logic [CHANNELS-1:0][CNT_W-1:0] p_q, p_d;
  logic [CHANNELS-1:0][CNT_W-1:0] c_q, c_d;
  logic [CHANNELS-1:0]            m_q, m_d;
  logic [CHANNELS-1:0]            busy_q, busy_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;

  logic             wr_hit;
  logic [CNT_W-1:0] eff_p;

  always_comb begin
    s     = (pre_q == PW'(PRESCALE - 1));
    pre_d = s ? '0 : pre_q + PW'(1);
  end

  // Priority per channel: stop, then start, then counting on the strobe.
  always_comb begin
    p_d    = p_q;
    m_d    = m_q;
    c_d    = c_q;
    busy_d = busy_q;
    tick_d = '0;
    wr_hit = 1'b0;
    eff_p  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit = i_wr_en && (i_wr_ch == CHW'(i));
      eff_p  = wr_hit ? i_wr_period : p_q[i];
      if (wr_hit) begin
        p_d[i] = i_wr_period;
        m_d[i] = i_wr_mode;
      end
      if (i_stop[i]) begin
        c_d[i]    = '0;
        busy_d[i] = 1'b0;
      end else if (i_start[i]) begin
        if (eff_p != '0) begin
          c_d[i]    = eff_p;
          busy_d[i] = 1'b1;
        end else begin
          c_d[i]    = '0;
          busy_d[i] = 1'b0;
        end
      end else if (s && busy_q[i]) begin
        if (c_q[i] == CNT_W'(1)) begin
          tick_d[i] = 1'b1;
          if (m_q[i] || (p_q[i] == '0)) begin
            c_d[i]    = '0;
            busy_d[i] = 1'b0;
          end else begin
            c_d[i] = p_q[i];
          end
        end else begin
          c_d[i] = c_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q  <= '0;
      bt_q   <= 1'b0;
      p_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      busy_q <= '0;
      tick_q <= '0;
    end else begin
      pre_q  <= pre_d;
      bt_q   <= s;
      p_q    <= p_d;
      m_q    <= m_d;
      c_q    <= c_d;
      busy_q <= busy_d;
      tick_q <= tick_d;
    end
  end

  assign o_base_tick = bt_q;
  assign o_tick      = tick_q;
  assign o_busy      = busy_q;

`ifdef TIMER_IRQ_EN
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic                irq_q;

  // Pending sets on the same edge o_tick rises; a new expiry beats a clear.
  always_comb begin
    pend_d = (pend_q & ~i_irq_clr) | tick_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_q;
    end
  end

  assign o_irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^i_irq_clr;
  assign o_irq          = 1'b0;
`endif

endmodule
